// File: rtl/avr_prog_loader.sv
// UART frame loader for AVR program memory: 0xA5, addr, cnt, cnt words (lo,hi) [, checksum when LOADER_CHECKSUM_EN].
// Write issued 1 clock after each hi byte, never stalls rx; core_hold/busy high while a frame is open.
module avr_prog_loader #(
  parameter int unsigned TIMEOUT = 25000000
) (
  input  logic        clock,
  input  logic        locked,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [15:0] pm_addr,
  output logic [15:0] pm_data,
  output logic        pm_we,
  output logic        core_hold,
  output logic        busy,
  output logic        err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0] SYNC = 8'hA5;

  typedef enum logic [2:0] {
    IDLE, ADDR_L, ADDR_H, CNT_L, CNT_H, DATA_L, DATA_H
`ifdef LOADER_CHECKSUM_EN
    , CSUM
`endif
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t END_ST = CSUM;
`else
  localparam state_t END_ST = IDLE;
`endif

  state_t        state_q, state_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [7:0]    lo_q, lo_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   pm_addr_q, pm_addr_d;
  logic [15:0]   pm_data_q, pm_data_d;
  logic          pm_we_q, pm_we_d;
  logic          err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  always_ff @(posedge clock or negedge locked) begin
    if (!locked) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      lo_q      <= '0;
      tmo_q     <= '0;
      pm_addr_q <= '0;
      pm_data_q <= '0;
      pm_we_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      lo_q      <= lo_d;
      tmo_q     <= tmo_d;
      pm_addr_q <= pm_addr_d;
      pm_data_q <= pm_data_d;
      pm_we_q   <= pm_we_d;
      err_q     <= err_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    lo_d      = lo_q;
    pm_addr_d = pm_addr_q;
    pm_data_d = pm_data_q;
    pm_we_d   = 1'b0;
    err_d     = 1'b0;
    tmo_d     = (rx_valid || state_q == IDLE) ? '0 : tmo_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
    csum_d    = csum_q;
    if (rx_valid && state_q != IDLE && state_q != CSUM) csum_d = csum_q + rx_data;
`endif

    case (state_q)
      IDLE: if (rx_valid && rx_data == SYNC) begin
        state_d = ADDR_L;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = '0;
`endif
      end
      ADDR_L: if (rx_valid) begin addr_d[7:0]  = rx_data; state_d = ADDR_H; end
      ADDR_H: if (rx_valid) begin addr_d[15:8] = rx_data; state_d = CNT_L;  end
      CNT_L:  if (rx_valid) begin cnt_d[7:0]   = rx_data; state_d = CNT_H;  end
      CNT_H: if (rx_valid) begin
        cnt_d[15:8] = rx_data;
        state_d     = ({rx_data, cnt_q[7:0]} == 16'd0) ? END_ST : DATA_L;
      end
      DATA_L: if (rx_valid) begin lo_d = rx_data; state_d = DATA_H; end
      DATA_H: begin
        // cnt==0 here is the cycle after the final write: leave only once pm_we has been seen.
        if (cnt_q == 16'd0) begin
          state_d = (rx_valid && rx_data == SYNC) ? ADDR_L : IDLE;
        end else if (rx_valid) begin
          pm_we_d   = 1'b1;
          pm_addr_d = addr_q;
          pm_data_d = {rx_data, lo_q};
          addr_d    = addr_q + 16'd1;
          cnt_d     = cnt_q - 16'd1;
`ifdef LOADER_CHECKSUM_EN
          state_d   = (cnt_q == 16'd1) ? CSUM : DATA_L;
`else
          state_d   = (cnt_q == 16'd1) ? DATA_H : DATA_L;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: if (rx_valid) begin
        err_d   = (rx_data != csum_q);
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && !rx_valid && tmo_q == TMO_LAST) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
  end

  assign pm_addr   = pm_addr_q;
  assign pm_data   = pm_data_q;
  assign pm_we     = pm_we_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);
  assign core_hold = (state_q != IDLE);

endmodule
